// File: rtl/spio_spinnaker_link_synchronous_receiver_pkg.sv
// Shared SpiNNaker link definitions: packet width, 2-of-7 code table, EOP code
// and the assembler state type. This package is the link header for the receiver.
package spio_spinnaker_link_synchronous_receiver_pkg;

  localparam int PKT_BITS = 72;

  // 2-of-7 transition codes for data nibbles 0..15
  localparam logic [6:0] NIB_CODE [16] = '{
    7'b0010001, 7'b0010010, 7'b0010100, 7'b0011000,
    7'b0100001, 7'b0100010, 7'b0100100, 7'b0101000,
    7'b1000001, 7'b1000010, 7'b1000100, 7'b1001000,
    7'b0000011, 7'b0000110, 7'b0001100, 7'b0001001
  };

  localparam logic [6:0] EOP_CODE = 7'b1100000;

  localparam logic [4:0] SHORT_NIBS = 5'd10;
  localparam logic [4:0] LONG_NIBS  = 5'd18;

  typedef enum logic [1:0] {
    ASM_IDLE,
    ASM_RECV,
    ASM_DROP
  } asm_state_t;

  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 7; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/spio_sl_rx_flit_decoder.sv
// 2-of-7 NRZ symbol decoder: tracks the last consumed link value, classifies the
// transition and toggles the acknowledge for every consumed symbol.
module spio_sl_rx_flit_decoder
  import spio_spinnaker_link_synchronous_receiver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] data_2of7,
  input  logic       eop_ok,
  output logic       ack,
  output logic       nib_vld,
  output logic [3:0] nib,
  output logic       eop_vld,
  output logic       flt
);

  logic [6:0]  synced;
  logic [6:0]  old_data_reg;
  logic [6:0]  diff;
  logic [2:0]  ones;
  logic [15:0] nib_hit;
  logic        is_eop;
  logic        illegal;
  logic        consume;
  logic        ack_reg;

  spio_spinnaker_link_sync #(.SIZE(7)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    (data_2of7),
    .synced (synced)
  );

  assign diff = synced ^ old_data_reg;
  assign ones = popcount7(diff);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_code
      assign nib_hit[gi] = (diff == NIB_CODE[gi]);
    end
  endgenerate

  always_comb begin
    nib = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (nib_hit[i]) nib = 4'(i);
    end
  end

  // Any two-hot transition that is neither a nibble nor EOP is one of the four
  // unused codes and is treated like a >2-bit glitch.
  assign is_eop  = (diff == EOP_CODE);
  assign illegal = (ones > 3'd2) || ((ones == 3'd2) && !(|nib_hit) && !is_eop);
  assign nib_vld = |nib_hit;
  assign eop_vld = is_eop && eop_ok;
  assign flt     = illegal;
  assign consume = nib_vld || eop_vld || illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      old_data_reg <= '0;
      ack_reg      <= 1'b0;
    end else if (consume) begin
      old_data_reg <= synced;
      ack_reg      <= ~ack_reg;
    end
  end

  assign ack = ack_reg;

endmodule

// File: rtl/spio_spinnaker_link_sync.sv
// Two-flop synchroniser bank bringing the asynchronous link wires into CLK domain.
module spio_spinnaker_link_sync #(
  parameter int SIZE = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] raw,
  output logic [SIZE-1:0] synced
);

  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_bit
      logic [1:0] stage_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_reg <= '0;
        else     stage_reg <= {stage_reg[0], raw[gi]};
      end
      assign synced[gi] = stage_reg[1];
    end
  endgenerate

endmodule

// File: rtl/spio_spinnaker_link_synchronous_receiver.sv
// SpiNNaker link receiver: packet assembler, frame/parity check and output register.
// Optional odd-parity check enabled by defining SPIO_SL_RX_PARITY_CHK_EN.
module spio_spinnaker_link_synchronous_receiver
  import spio_spinnaker_link_synchronous_receiver_pkg::*;
(
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic [6:0]          SL_DATA_2OF7_IN,
  output logic                SL_ACK_OUT,
  output logic [PKT_BITS-1:0] PKT_DATA_OUT,
  output logic                PKT_VLD_OUT,
  input  logic                PKT_RDY_IN,
  output logic                FLT_ERR_OUT,
  output logic                FRM_ERR_OUT,
  output logic                PAR_ERR_OUT
);

`ifdef SPIO_SL_RX_PARITY_CHK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  logic                nib_vld;
  logic [3:0]          nib;
  logic                eop_vld;
  logic                flt;
  logic                eop_ok;

  asm_state_t          state_reg, state_next;
  logic [4:0]          nib_cnt_reg, nib_cnt_next;
  logic [PKT_BITS-1:0] asm_reg, asm_next;
  logic [PKT_BITS-1:0] pkt_data_reg, pkt_data_next;
  logic                pkt_vld_reg, pkt_vld_next;
  logic                flt_err_reg;
  logic                frm_err_reg, frm_err_next;
  logic                par_err_reg, par_err_next;
  logic                load;
  logic                frame_ok;
  logic                parity_ok;

  // EOP may only be consumed when the output register can take a packet.
  assign eop_ok = !pkt_vld_reg || PKT_RDY_IN;

  spio_sl_rx_flit_decoder u_dec (
    .clk       (CLK_IN),
    .rst       (RESET_IN),
    .data_2of7 (SL_DATA_2OF7_IN),
    .eop_ok    (eop_ok),
    .ack       (SL_ACK_OUT),
    .nib_vld   (nib_vld),
    .nib       (nib),
    .eop_vld   (eop_vld),
    .flt       (flt)
  );

  // Unwritten bits stay zero, so the full-width XOR also covers short packets.
  assign frame_ok  = ((nib_cnt_reg == SHORT_NIBS) && !asm_reg[1]) ||
                     ((nib_cnt_reg == LONG_NIBS)  &&  asm_reg[1]);
  assign parity_ok = !PAR_CHK || (^asm_reg);

  always_comb begin
    state_next   = state_reg;
    nib_cnt_next = nib_cnt_reg;
    asm_next     = asm_reg;
    frm_err_next = 1'b0;
    par_err_next = 1'b0;
    load         = 1'b0;

    if (flt) begin
      state_next   = ASM_IDLE;
      nib_cnt_next = '0;
      asm_next     = '0;
    end else if (nib_vld) begin
      if (state_reg != ASM_DROP) begin
        if (nib_cnt_reg == LONG_NIBS) begin
          frm_err_next = 1'b1;
          state_next   = ASM_DROP;
          nib_cnt_next = '0;
          asm_next     = '0;
        end else begin
          asm_next[{nib_cnt_reg, 2'b00} +: 4] = nib;
          nib_cnt_next = nib_cnt_reg + 5'd1;
          state_next   = ASM_RECV;
        end
      end
    end else if (eop_vld) begin
      if (state_reg != ASM_DROP) begin
        if (!frame_ok)       frm_err_next = 1'b1;
        else if (!parity_ok) par_err_next = 1'b1;
        else                 load         = 1'b1;
      end
      state_next   = ASM_IDLE;
      nib_cnt_next = '0;
      asm_next     = '0;
    end

    pkt_vld_next  = load ? 1'b1 : (pkt_vld_reg && !PKT_RDY_IN);
    pkt_data_next = load ? asm_reg : pkt_data_reg;
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_reg    <= ASM_IDLE;
      nib_cnt_reg  <= '0;
      asm_reg      <= '0;
      pkt_data_reg <= '0;
      pkt_vld_reg  <= 1'b0;
      flt_err_reg  <= 1'b0;
      frm_err_reg  <= 1'b0;
      par_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      nib_cnt_reg  <= nib_cnt_next;
      asm_reg      <= asm_next;
      pkt_data_reg <= pkt_data_next;
      pkt_vld_reg  <= pkt_vld_next;
      flt_err_reg  <= flt;
      frm_err_reg  <= frm_err_next;
      par_err_reg  <= par_err_next;
    end
  end

  assign PKT_DATA_OUT = pkt_data_reg;
  assign PKT_VLD_OUT  = pkt_vld_reg;
  assign FLT_ERR_OUT  = flt_err_reg;
  assign FRM_ERR_OUT  = frm_err_reg;
`ifdef SPIO_SL_RX_PARITY_CHK_EN
  assign PAR_ERR_OUT  = par_err_reg;
`else
  assign PAR_ERR_OUT  = 1'b0;
`endif

endmodule

// File: tb/tb_spio_spinnaker_link_synchronous_receiver.sv
// Bench for the SpiNNaker link receiver: NRZ 2-of-7 sender model plus packet scoreboard.
module tb_spio_spinnaker_link_synchronous_receiver;
  import spio_spinnaker_link_synchronous_receiver_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  sl_data;
  logic        sl_ack;
  logic [71:0] pkt_data;
  logic        pkt_vld;
  logic        pkt_rdy;
  logic        flt_err, frm_err, par_err;

  always #5 clk = ~clk;

  spio_spinnaker_link_synchronous_receiver dut (
    .CLK_IN          (clk),
    .RESET_IN        (rst),
    .SL_DATA_2OF7_IN (sl_data),
    .SL_ACK_OUT      (sl_ack),
    .PKT_DATA_OUT    (pkt_data),
    .PKT_VLD_OUT     (pkt_vld),
    .PKT_RDY_IN      (pkt_rdy),
    .FLT_ERR_OUT     (flt_err),
    .FRM_ERR_OUT     (frm_err),
    .PAR_ERR_OUT     (par_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [71:0] exp_q[$];
  int   ack_cnt = 0, flt_cnt = 0, frm_cnt = 0, par_cnt = 0, dlv_cnt = 0;
  logic ack_prev = 1'b0;

  // Monitor: counts ack toggles and error-high cycles, scores delivered packets.
  always @(negedge clk) begin
    if (sl_ack !== ack_prev) ack_cnt <= ack_cnt + 1;
    ack_prev <= sl_ack;
    if (flt_err) flt_cnt <= flt_cnt + 1;
    if (frm_err) frm_cnt <= frm_cnt + 1;
    if (par_err) par_cnt <= par_cnt + 1;
    if (pkt_vld && pkt_rdy) begin
      check_eq("sb_pending", 72'(exp_q.size() != 0), 72'(1));
      if (exp_q.size() != 0) begin
        $display("pkt delivered: %018h", pkt_data);
        check_eq("pkt_data", pkt_data, exp_q.pop_front());
        dlv_cnt <= dlv_cnt + 1;
      end
    end
  end

  logic [6:0] link = 7'd0;

  task automatic wait_ack(input logic prev, input string tag);
    int n = 0;
    while (sl_ack === prev && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sl_ack === prev) check_eq(tag, 72'(sl_ack), 72'(~prev));
  endtask

  task automatic send_sym(input logic [6:0] code, input bit skew);
    logic       prev;
    logic [6:0] low;
    prev = sl_ack;
    if (skew) begin
      low = code & (~code + 7'd1);
      link ^= low;
      sl_data = link;
      repeat (3) @(posedge clk);
      #1;
      link ^= code ^ low;
    end else begin
      link ^= code;
    end
    sl_data = link;
    wait_ack(prev, "ack_timeout");
  endtask

  function automatic bit pkt_ok(input logic [71:0] pkt, input int nibs);
    bit ok;
    ok = (nibs == 10 && !pkt[1]) || (nibs == 18 && pkt[1]);
`ifdef SPIO_SL_RX_PARITY_CHK_EN
    ok = ok && (^pkt);
`endif
    return ok;
  endfunction

  task automatic send_nibs(input logic [71:0] pkt, input int nibs, input bit skew);
    for (int i = 0; i < nibs; i++) send_sym(NIB_CODE[pkt[4*i +: 4]], skew);
  endtask

  task automatic send_pkt(input logic [71:0] pkt, input int nibs, input bit skew);
    send_nibs(pkt, nibs, skew);
    if (pkt_ok(pkt, nibs)) exp_q.push_back(pkt);
    send_sym(EOP_CODE, skew);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    check_eq("drain", 72'(exp_q.size()), 72'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          a0, f0, e0, d0;
    logic        lvl;
    logic [71:0] long_pkt, short2;

    rst = 1'b1; pkt_rdy = 1'b0; sl_data = 7'd0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_ack", 72'(sl_ack), 72'(0));
    check_eq("rst_vld", 72'(pkt_vld), 72'(0));
    check_eq("rst_data", pkt_data, 72'(0));
    check_eq("rst_errs", 72'({flt_err, frm_err, par_err}), 72'(0));
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Short packet, consumer ready
    pkt_rdy = 1'b1; a0 = ack_cnt; d0 = dlv_cnt;
    send_pkt(72'h00_0000_0001, 10, 1'b0);
    wait_drain();
    check_eq("short_acks", 72'(ack_cnt - a0), 72'(11));
    check_eq("short_dlv", 72'(dlv_cnt - d0), 72'(1));

    // Long packet with backpressure, second EOP withheld
    long_pkt = 72'h00_DEAD_BEEF_0000_0002;
    short2   = 72'h00_0000_0012_3456_7811;
    pkt_rdy = 1'b0; d0 = dlv_cnt;
    send_pkt(long_pkt, 18, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("bp_vld", 72'(pkt_vld), 72'(1));
    check_eq("bp_data", pkt_data, long_pkt);
    send_nibs(short2, 10, 1'b0);
    exp_q.push_back(short2);
    lvl = sl_ack;
    link ^= EOP_CODE;
    sl_data = link;
    repeat (30) @(posedge clk);
    #1;
    check_eq("bp_eop_held", 72'(sl_ack), 72'(lvl));
    check_eq("bp_stable", pkt_data, long_pkt);
    pkt_rdy = 1'b1;
    wait_ack(lvl, "bp_ack_resume");
    wait_drain();
    check_eq("bp_dlv", 72'(dlv_cnt - d0), 72'(2));

    // Illegal symbol mid-packet
    f0 = flt_cnt; a0 = ack_cnt; d0 = dlv_cnt;
    send_nibs(72'h0000_0000_0000_4321, 4, 1'b0);
    send_sym(7'b0110000, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("flt_pulse", 72'(flt_cnt - f0), 72'(1));
    check_eq("flt_acks", 72'(ack_cnt - a0), 72'(5));
    send_pkt(72'h00_0000_00A4, 10, 1'b0);
    wait_drain();
    check_eq("flt_dlv", 72'(dlv_cnt - d0), 72'(1));

    // Framing errors: short EOP and overlong packet
    e0 = frm_cnt; d0 = dlv_cnt;
    send_pkt(72'h0, 7, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("frm_short", 72'(frm_cnt - e0), 72'(1));
    send_pkt(72'h0, 20, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("frm_long", 72'(frm_cnt - e0), 72'(2));
    check_eq("frm_dlv", 72'(dlv_cnt - d0), 72'(0));

    // Skewed link bits
    f0 = flt_cnt; a0 = ack_cnt; d0 = dlv_cnt;
    send_pkt(72'h98_7654_3210, 10, 1'b1);
    wait_drain();
    check_eq("skew_flt", 72'(flt_cnt - f0), 72'(0));
    check_eq("skew_acks", 72'(ack_cnt - a0), 72'(11));
    check_eq("skew_dlv", 72'(dlv_cnt - d0), 72'(1));

`ifdef SPIO_SL_RX_PARITY_CHK_EN
    // Even parity is rejected
    e0 = par_cnt; d0 = dlv_cnt;
    send_pkt(72'h5, 10, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("par_pulse", 72'(par_cnt - e0), 72'(1));
    check_eq("par_dlv", 72'(dlv_cnt - d0), 72'(0));
`endif

    // Reset mid-packet
    f0 = flt_cnt + frm_cnt + par_cnt; d0 = dlv_cnt;
    send_nibs(72'h0000_0000_0000_5555, 5, 1'b0);
    rst = 1'b1; link = 7'd0; sl_data = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_rst_outs", 72'({sl_ack, pkt_vld, flt_err, frm_err, par_err}), 72'(0));
    check_eq("mid_rst_data", pkt_data, 72'(0));
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_pkt(72'h03_0000_0001, 10, 1'b0);
    wait_drain();
    check_eq("rst_no_err", 72'(flt_cnt + frm_cnt + par_cnt), 72'(f0));
    check_eq("rst_dlv", 72'(dlv_cnt - d0), 72'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spio_spinnaker_link_synchronous_receiver.md
SPIO_SPINNAKER_LINK_SYNCHRONOUS_RECEIVER -- requirements
Module: spio_spinnaker_link_synchronous_receiver

Interface
REQ-001 SHALL have no module parameters; PKT_BITS (72) SHALL come from the shared link header.
REQ-002 CLK_IN  input  1  system clock.
REQ-003 RESET_IN  input  1  reset, asynchronous, active-high.
REQ-004 SL_DATA_2OF7_IN  input  7  asynchronous NRZ 2-of-7 link data.
REQ-005 SL_ACK_OUT  output  1  NRZ acknowledge; one toggle per accepted symbol.
REQ-006 PKT_DATA_OUT  output  PKT_BITS  received packet; short packets zero-extended above bit 39.
REQ-007 PKT_VLD_OUT  output  1  packet valid.
REQ-008 PKT_RDY_IN  input  1  consumer ready; transfer when PKT_VLD_OUT && PKT_RDY_IN.
REQ-009 FLT_ERR_OUT  output  1  one-cycle pulse on an illegal symbol.
REQ-010 FRM_ERR_OUT  output  1  one-cycle pulse on a framing error.
REQ-011 PAR_ERR_OUT  output  1  one-cycle pulse on a parity failure (see Configuration).

Function
REQ-012 SL_DATA_2OF7_IN SHALL pass through spio_spinnaker_link_sync (SIZE 7) before use; all timing below is relative to the synchronised value.
REQ-013 Decoder SHALL keep old_data (7 bits) and compute diff = synced ^ old_data.
REQ-014 popcount(diff) < 2: no symbol, and the decoder SHALL wait.
REQ-015 popcount(diff) == 2: symbol complete; codes per SpiNNaker 2-of-7 table: nibbles 0-15 and EOP = 7'b1100000.
REQ-016 diff in {0000101, 0001010, 0110000, 1010000}, or popcount(diff) > 2: illegal symbol; FLT_ERR_OUT pulses, the packet in progress is discarded, and the symbol is consumed and acked.
REQ-017 Consuming a symbol at edge k SHALL set old_data <= synced and toggle SL_ACK_OUT at edge k.
REQ-018 Data nibbles SHALL be consumed immediately.
REQ-019 EOP SHALL be consumed only when !PKT_VLD_OUT || PKT_RDY_IN; otherwise the ack is withheld, providing backpressure.
REQ-020 Assembly: nibble n (from 0) SHALL be written to bits [4n+3:4n]; the long flag is bit 1 of nibble 0; nib_cnt SHALL saturate at 18.
REQ-021 Frame check: EOP with nib_cnt == 10 (short) or 18 (long) is good; any other EOP count, or a 19th data nibble, SHALL pulse FRM_ERR_OUT and discard the packet.
REQ-022 After a framing error, the data nibbles up to and including the next EOP SHALL be discarded.
REQ-023 A good EOP consumed at edge k SHALL load PKT_DATA_OUT and assert PKT_VLD_OUT at edge k (visible at cycle k+1), then reset the assembler.
REQ-024 PKT_VLD_OUT SHALL hold until the transfer.
REQ-025 PKT_DATA_OUT SHALL be stable while PKT_VLD_OUT && !PKT_RDY_IN.
REQ-026 Simultaneous transfer and good EOP SHALL load the new packet with PKT_VLD_OUT staying 1, giving no bubble.
REQ-027 Assembler states: IDLE (nib_cnt 0) -> RECV (first nibble) -> IDLE on EOP. RECV -> DROP on framing error; DROP -> IDLE on EOP. Any state -> IDLE on an illegal symbol.

Reset
REQ-028 On RESET_IN: SL_ACK_OUT=0, old_data=0, PKT_VLD_OUT=0, PKT_DATA_OUT=0, all error outputs 0, assembler IDLE with nib_cnt 0.
REQ-029 Reset mid-packet SHALL discard the partial packet with no error pulse.

Configuration
REQ-030 SPIO_SL_RX_PARITY_CHK_EN defined: a good-framed packet whose XOR over bits [39:0] (short) or [71:0] (long) != 1 (odd parity) SHALL be dropped and SHALL pulse PAR_ERR_OUT at edge k.
REQ-031 SPIO_SL_RX_PARITY_CHK_EN undefined: no parity check; PAR_ERR_OUT tied 0.

Structure
REQ-032 PKT_BITS, the 2-of-7 code constants and the EOP code SHALL live in shared header spio_spinnaker_link.h.
REQ-033 Sub-module spio_sl_rx_flit_decoder SHALL hold the decode, old_data and ack logic; the top SHALL hold the assembler and output register.

Verification
REQ-034 Short packet 0x00_0000_0001 sent as 10 nibbles + EOP with PKT_RDY_IN=1 -> one PKT_VLD_OUT pulse with PKT_DATA_OUT=72'h00_0000_0001; 11 SL_ACK_OUT toggles.
REQ-035 Long packet (bit1=1, payload 0xDEADBEEF) sent with PKT_RDY_IN=0 -> PKT_VLD_OUT held; second packet's EOP unacked; raising PKT_RDY_IN -> ack resumes and both packets are delivered in order.
REQ-036 diff=7'b0110000 mid-packet -> FLT_ERR_OUT=1 for 1 cycle; ack toggles; no packet is delivered; the next good packet is delivered.
REQ-037 EOP after 7 nibbles -> FRM_ERR_OUT pulse, no PKT_VLD_OUT; 20 nibbles then EOP -> one FRM_ERR_OUT pulse.
REQ-038 Link bits of one symbol skewed 3 cycles apart -> no error; one ack per symbol.
REQ-039 SPIO_SL_RX_PARITY_CHK_EN defined, short packet with even parity -> PAR_ERR_OUT pulse, no PKT_VLD_OUT; RESET_IN asserted after 5 nibbles -> all outputs 0, next packet delivered.
